// File: rtl/fp_add_unpack_pkg.sv
// Shared definitions for the FP adder unpack stage: field width defaults,
// bias helper and skid-buffer state encoding.
package fp_add_unpack_pkg;

    localparam int unsigned E_WIDTH_DEF = 8;
    localparam int unsigned M_WIDTH_DEF = 23;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Exponent bias base; the value subtracted from a raw field is bias-1.
    function automatic int unsigned calc_bias(input int unsigned e_width);
        return 32'(1) << (e_width - 1);
    endfunction

endpackage

// File: rtl/fp_add_unpack_if.sv
// Handshake and payload bundle between the operand source, the unpack
// stage and the special-case stage that consumes the unpacked fields.
interface fp_add_unpack_if
    import fp_add_unpack_pkg::*;
#(
    parameter int unsigned E_WIDTH = E_WIDTH_DEF,
    parameter int unsigned M_WIDTH = M_WIDTH_DEF
);
    localparam int unsigned W = E_WIDTH + M_WIDTH + 1;

    logic               in_valid;
    logic               in_ready;
    logic [W-1:0]       op_A;
    logic [W-1:0]       op_B;
    logic               sub;

    logic               out_valid;
    logic               out_ready;
    logic               sign_A;
    logic               sign_B;
    logic [E_WIDTH-1:0] exp_A;
    logic [E_WIDTH-1:0] exp_B;
    logic [E_WIDTH-1:0] exp_A_org;
    logic [E_WIDTH-1:0] exp_B_org;
    logic [M_WIDTH-1:0] mnt_A;
    logic [M_WIDTH-1:0] mnt_B;
    logic               hid_A;
    logic               hid_B;

    modport master (
        output in_valid, op_A, op_B, sub, out_ready,
        input  in_ready, out_valid,
        input  sign_A, sign_B, exp_A, exp_B, exp_A_org, exp_B_org,
        input  mnt_A, mnt_B, hid_A, hid_B
    );

    modport slave (
        input  in_valid, op_A, op_B, sub, out_ready,
        output in_ready, out_valid,
        output sign_A, sign_B, exp_A, exp_B, exp_A_org, exp_B_org,
        output mnt_A, mnt_B, hid_A, hid_B
    );

endinterface

// File: rtl/fp_unpack_field.sv
// Combinational split of one IEEE-style operand into sign, unbiased exponent,
// raw exponent, raw fraction and hidden bit.
module fp_unpack_field
    import fp_add_unpack_pkg::*;
#(
    parameter int unsigned E_WIDTH = E_WIDTH_DEF,
    parameter int unsigned M_WIDTH = M_WIDTH_DEF
) (
    input  logic [E_WIDTH+M_WIDTH:0] i_op,
    input  logic                     i_inv_sign,
    output logic                     o_sign_c,
    output logic [E_WIDTH-1:0]       o_exp_c,
    output logic [E_WIDTH-1:0]       o_exp_org_c,
    output logic [M_WIDTH-1:0]       o_mnt_c,
    output logic                     o_hid_c
);
    localparam int unsigned W    = E_WIDTH + M_WIDTH + 1;
    localparam int unsigned BIAS = calc_bias(E_WIDTH);
    localparam logic [E_WIDTH-1:0] UNBIAS = E_WIDTH'(BIAS - 1);

    logic [E_WIDTH-1:0] w_exp_org;

    assign w_exp_org   = i_op[W-2 -: E_WIDTH];
    assign o_sign_c    = i_op[W-1] ^ i_inv_sign;
    assign o_exp_org_c = w_exp_org;
    // Wraps modulo 2^E_WIDTH, so zero and all-ones fields land on BIAS+1 and BIAS.
    assign o_exp_c     = w_exp_org - UNBIAS;
    assign o_mnt_c     = i_op[M_WIDTH-1:0];
    assign o_hid_c     = |w_exp_org;

endmodule

// File: rtl/fp_add_unpack.sv
// FP adder front stage: unpacks an operand pair (B sign flipped for subtract)
// and holds it in a two-entry skid buffer with a registered in_ready.
module fp_add_unpack
    import fp_add_unpack_pkg::*;
#(
    parameter int unsigned E_WIDTH = E_WIDTH_DEF,
    parameter int unsigned M_WIDTH = M_WIDTH_DEF
) (
    input  logic            clk,
    input  logic            rst,
    fp_add_unpack_if.slave  bus
);
    typedef struct packed {
        logic               sign_a;
        logic               sign_b;
        logic [E_WIDTH-1:0] exp_a;
        logic [E_WIDTH-1:0] exp_b;
        logic [E_WIDTH-1:0] exp_a_org;
        logic [E_WIDTH-1:0] exp_b_org;
        logic [M_WIDTH-1:0] mnt_a;
        logic [M_WIDTH-1:0] mnt_b;
        logic               hid_a;
        logic               hid_b;
    } unp_t;

    logic               w_sign_a, w_sign_b, w_hid_a, w_hid_b;
    logic [E_WIDTH-1:0] w_exp_a, w_exp_b, w_exp_a_org, w_exp_b_org;
    logic [M_WIDTH-1:0] w_mnt_a, w_mnt_b;
    unp_t               w_unp;
    logic               w_accept;
    logic               w_pop;

    state_t             r_state;
    unp_t               r_main;
    unp_t               r_skid;
    logic               r_in_ready;
    logic               r_out_valid;

    fp_unpack_field #(.E_WIDTH(E_WIDTH), .M_WIDTH(M_WIDTH)) u_unp_a (
        .i_op        (bus.op_A),
        .i_inv_sign  (1'b0),
        .o_sign_c    (w_sign_a),
        .o_exp_c     (w_exp_a),
        .o_exp_org_c (w_exp_a_org),
        .o_mnt_c     (w_mnt_a),
        .o_hid_c     (w_hid_a)
    );

    fp_unpack_field #(.E_WIDTH(E_WIDTH), .M_WIDTH(M_WIDTH)) u_unp_b (
        .i_op        (bus.op_B),
        .i_inv_sign  (bus.sub),
        .o_sign_c    (w_sign_b),
        .o_exp_c     (w_exp_b),
        .o_exp_org_c (w_exp_b_org),
        .o_mnt_c     (w_mnt_b),
        .o_hid_c     (w_hid_b)
    );

    assign w_unp    = {w_sign_a, w_sign_b, w_exp_a, w_exp_b, w_exp_a_org, w_exp_b_org,
                       w_mnt_a, w_mnt_b, w_hid_a, w_hid_b};
    assign w_accept = bus.in_valid && r_in_ready;
    assign w_pop    = r_out_valid && bus.out_ready;

    // Skid-buffer control; in_ready is loaded with "next state is not FULL".
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= EMPTY;
            r_main      <= '0;
            r_skid      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_state     <= ONE;
                        r_main      <= w_unp;
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b1;
                    end
                end
                ONE: begin
                    if (w_accept && !w_pop) begin
                        r_state    <= FULL;
                        r_skid     <= w_unp;
                        r_in_ready <= 1'b0;
                    end else if (!w_accept && w_pop) begin
                        r_state     <= EMPTY;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end else if (w_accept && w_pop) begin
                        r_main <= w_unp;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a pop can move the state.
                    if (w_pop) begin
                        r_state    <= ONE;
                        r_main     <= r_skid;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.sign_A    = r_main.sign_a;
    assign bus.sign_B    = r_main.sign_b;
    assign bus.exp_A     = r_main.exp_a;
    assign bus.exp_B     = r_main.exp_b;
    assign bus.exp_A_org = r_main.exp_a_org;
    assign bus.exp_B_org = r_main.exp_b_org;
    assign bus.mnt_A     = r_main.mnt_a;
    assign bus.mnt_B     = r_main.mnt_b;
    assign bus.hid_A     = r_main.hid_a;
    assign bus.hid_B     = r_main.hid_b;

endmodule

// File: tb/tb_fp_add_unpack.sv
// Bench for fp_add_unpack: queue-based reference of the two-entry buffer with
// unpacked values computed arithmetically from the operand encoding.
module tb_fp_add_unpack;
    import fp_add_unpack_pkg::*;

    logic clk;
    logic rst;

    int n_checks;
    int n_errors;

    logic [81:0] q[$];
    logic        m_ready;

    fp_add_unpack_if bus ();

    fp_add_unpack u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [81:0] got, input logic [81:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected unpacked tuple for the default 8/23 format.
    function automatic logic [81:0] ref_unpack(input logic [31:0] a, input logic [31:0] b,
                                               input logic s);
        int ea, eb, ua, ub;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        ua = (ea + 256 - 127) % 256;
        ub = (eb + 256 - 127) % 256;
        return {a[31], b[31] ^ s, 8'(ua), 8'(ub), a[30:23], b[30:23],
                a[22:0], b[22:0], ea != 0, eb != 0};
    endfunction

    function automatic logic [81:0] obs();
        return {bus.sign_A, bus.sign_B, bus.exp_A, bus.exp_B, bus.exp_A_org, bus.exp_B_org,
                bus.mnt_A, bus.mnt_B, bus.hid_A, bus.hid_B};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0:       r[30:23] = 8'h00;
            1:       r[30:23] = 8'hFF;
            default: ;
        endcase
        return r;
    endfunction

    // One clock: drive inputs, advance the reference, check handshake and head data.
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic ordy);
        logic        acc;
        logic        pop;
        logic [81:0] dummy;
        bus.in_valid  = v;
        bus.op_A      = a;
        bus.op_B      = b;
        bus.sub       = s;
        bus.out_ready = ordy;
        acc = v && m_ready;
        pop = (q.size() != 0) && ordy;
        @(posedge clk);
        #1;
        if (pop) dummy = q.pop_front();
        if (acc) q.push_back(ref_unpack(a, b, s));
        m_ready = (q.size() < 2);
        check_eq("in_ready", 82'(bus.in_ready), 82'(m_ready));
        check_eq("out_valid", 82'(bus.out_valid), 82'(q.size() != 0));
        if (q.size() != 0) check_eq("data", obs(), q[0]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_out_valid"}, 82'(bus.out_valid), 82'(0));
        check_eq({tag, "_in_ready"}, 82'(bus.in_ready), 82'(1));
        check_eq({tag, "_data"}, obs(), 82'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ra, rb;
        n_checks = 0;
        n_errors = 0;
        m_ready  = 1'b1;
        rst      = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op_A      = '0;
        bus.op_B      = '0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        // Normal values, first accept right after reset release.
        step(1'b1, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0);
        check_eq("norm_exp_A", 82'(bus.exp_A), 82'(8'h00));
        check_eq("norm_exp_B", 82'(bus.exp_B), 82'(8'h01));
        check_eq("norm_hid", 82'({bus.hid_A, bus.hid_B}), 82'(2'b11));
        check_eq("norm_mnt", 82'({bus.mnt_A, bus.mnt_B}), 82'(0));
        check_eq("norm_signs", 82'({bus.sign_A, bus.sign_B}), 82'(2'b00));
        step(1'b0, '0, '0, 1'b0, 1'b1);

        // Inf and zero with subtract.
        step(1'b1, 32'h7F80_0000, 32'h0000_0000, 1'b1, 1'b0);
        check_eq("spec_exp_A", 82'(bus.exp_A), 82'(8'h80));
        check_eq("spec_exp_A_org", 82'(bus.exp_A_org), 82'(8'hFF));
        check_eq("spec_exp_B", 82'(bus.exp_B), 82'(8'h81));
        check_eq("spec_sign_B", 82'(bus.sign_B), 82'(1));
        check_eq("spec_hid_B", 82'(bus.hid_B), 82'(0));
        step(1'b0, '0, '0, 1'b0, 1'b1);

        // Denormal and NaN.
        step(1'b1, 32'h0000_0001, 32'h7FC0_0000, 1'b0, 1'b0);
        check_eq("dn_exp_A", 82'(bus.exp_A), 82'(8'h81));
        check_eq("dn_mnt_A", 82'(bus.mnt_A), 82'(1));
        check_eq("dn_hid_A", 82'(bus.hid_A), 82'(0));
        check_eq("nan_exp_B", 82'(bus.exp_B), 82'(8'h80));
        check_eq("nan_mnt_B", 82'(bus.mnt_B), 82'(23'h40_0000));
        step(1'b0, '0, '0, 1'b0, 1'b1);

        // Backpressure: three pairs offered, two taken, then drain in order.
        step(1'b1, 32'h3F80_0000, 32'h3F80_0001, 1'b0, 1'b0);
        step(1'b1, 32'h4040_0000, 32'hC040_0000, 1'b1, 1'b0);
        check_eq("bp_in_ready_low", 82'(bus.in_ready), 82'(0));
        step(1'b1, 32'h4080_0000, 32'h4100_0000, 1'b0, 1'b0);
        step(1'b1, 32'h4080_0000, 32'h4100_0000, 1'b0, 1'b0);
        step(1'b1, 32'h4080_0000, 32'h4100_0000, 1'b0, 1'b1);
        step(1'b1, 32'h4080_0000, 32'h4100_0000, 1'b0, 1'b1);
        check_eq("bp_third_accepted", 82'(q.size()), 82'(1));
        step(1'b0, '0, '0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1);

        // Streaming at full rate.
        for (int i = 0; i < 16; i++) begin
            ra = rand_op();
            rb = rand_op();
            step(1'b1, ra, rb, 1'(i & 1), 1'b1);
            check_eq("stream_in_ready", 82'(bus.in_ready), 82'(1));
        end
        step(1'b0, '0, '0, 1'b0, 1'b1);

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            ra = rand_op();
            rb = rand_op();
            step(1'($urandom_range(0, 3) != 0), ra, rb, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 2) != 0));
        end

        // Reset while FULL discards both entries.
        step(1'b0, '0, '0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        step(1'b1, 32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0);
        step(1'b1, 32'h4040_0000, 32'h4040_0000, 1'b0, 1'b0);
        check_eq("full_before_reset", 82'(bus.in_ready), 82'(0));
        bus.in_valid = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        check_reset_outputs("reset_full");
        q.delete();
        m_ready = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b1;
        step(1'b0, '0, '0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1);

        // Accept on the very first edge after a release.
        #2;
        rst = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        step(1'b1, 32'hBF80_0000, 32'h0080_0000, 1'b1, 1'b1);
        check_eq("first_edge_accept", 82'(bus.out_valid), 82'(1));
        step(1'b0, '0, '0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fp_add_unpack.md
FP_ADD_UNPACK -- requirements
Module: fp_add_unpack

Interface
REQ-001 Parameters SHALL be:
- E_WIDTH, default 8, exponent field width.
- M_WIDTH, default 23, fraction field width.
- W = E_WIDTH+M_WIDTH+1, derived, operand width.
- BIAS = 1<<(E_WIDTH-1), derived; the unbias offset is BIAS-1.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  the single clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  stage can accept a pair.
- op_A  in  W  IEEE-style operand A {sign, exp, frac}.
- op_B  in  W  operand B.
- sub  in  1  1 = A−B, 0 = A+B.
- out_valid  out  1  unpacked pair valid.
- out_ready  in  1  downstream accepts.
- sign_A, sign_B  out  1 each  effective signs.
- exp_A, exp_B  out  E_WIDTH each  unbiased exponents, two's complement.
- exp_A_org, exp_B_org  out  E_WIDTH each  raw exponent fields.
- mnt_A, mnt_B  out  M_WIDTH each  raw fraction fields.
- hid_A, hid_B  out  1 each  hidden bit.

REQ-003 Clock and reset are fixed as one clock, clk; reset rst is asynchronous and active-low.

Function
REQ-004 The block SHALL unpack one operand pair per accepted transfer. Transfers:
- Accept = in_valid && in_ready at a clk edge.
- Pop = out_valid && out_ready at a clk edge.

REQ-005 exp_X SHALL equal exp_X_org − (BIAS−1), modulo 2^E_WIDTH.
- All-ones field (Inf/NaN) maps to BIAS (0x80).
- Zero field maps to BIAS+1 (0x81).

REQ-006 Sign and fraction fields:
- sign_A SHALL equal op_A[W-1].
- sign_B SHALL equal op_B[W-1] XOR sub.
- mnt_X SHALL equal op_X[M_WIDTH-1:0], unmodified.

REQ-007 hid_X SHALL be 1 when exp_X_org != 0, else 0.

REQ-008 Buffering SHALL be a two-entry skid buffer (main register plus skid register) with states EMPTY, ONE, FULL.

REQ-009 State transitions SHALL be:
- EMPTY, accept: go to ONE, main ← input.
- ONE, accept without pop: go to FULL, skid ← input.
- ONE, pop without accept: go to EMPTY.
- ONE, accept and pop together: stay ONE, main ← input.
- FULL, pop: go to ONE, main ← skid.
- All other cases: hold.

REQ-010 in_ready SHALL be a registered output, 1 exactly when the next state is not FULL. It SHALL NOT depend combinationally on out_ready.

REQ-011 out_valid SHALL be 1 in ONE and FULL. All data outputs SHALL be driven from the main register.

REQ-012 Latency SHALL be one cycle: an accept into EMPTY gives out_valid=1 on the next cycle.

REQ-013 While out_valid=1 and out_ready=0, all data outputs SHALL hold stable.

REQ-014 Sustained throughput SHALL be one pair per cycle when out_ready is held at 1.

REQ-015 Operand ordering SHALL be preserved; no pair SHALL be dropped or duplicated.

REQ-016 Unpacking SHALL be computed before the main and skid registers, so both registers store unpacked fields.

Reset
REQ-017 While rst=0 the block SHALL force:
- state = EMPTY.
- out_valid = 0.
- in_ready = 1.
- All data outputs and the skid register = 0.

REQ-018 Reset asserted mid-transfer SHALL discard both buffered entries with no partial output.

REQ-019 The first accept SHALL be possible at the first clk edge after rst deasserts.

Structure
REQ-020 A shared package SHALL hold:
- E_WIDTH and M_WIDTH defaults and the BIAS formula.
- The state encoding (EMPTY=0, ONE=1, FULL=2).

REQ-021 The unpack arithmetic SHALL be one combinational sub-module, fp_unpack_field, instantiated once per operand. It takes an operand and an invert-sign flag and returns sign, exp, exp_org, mnt and hid.

REQ-022 The outputs SHALL connect directly, by name and width, to the special-case stage's inputs sign_A, sign_B, exp_A, exp_B, exp_A_org, exp_B_org, mnt_A, mnt_B.

Verification
REQ-023 Normal values: op_A=0x3F800000, op_B=0x40000000, sub=0 → next cycle out_valid=1, exp_A=0x00, exp_B=0x01, hid_A=hid_B=1, mnt=0, signs 0.

REQ-024 Specials: op_A=0x7F800000, op_B=0x00000000, sub=1 → exp_A=0x80, exp_A_org=0xFF, exp_B=0x81, sign_B=1, hid_B=0.

REQ-025 Denormal and NaN: op_A=0x00000001, op_B=0x7FC00000 → exp_A=0x81, mnt_A=1, hid_A=0; exp_B=0x80, mnt_B=0x400000.

REQ-026 Backpressure: hold out_ready=0 and offer 3 pairs → 2 accepted, in_ready=0 after the second, outputs stable. Raise out_ready → all 3 emerge in order, one per cycle.

REQ-027 Streaming: in_valid=1 and out_ready=1 for 16 cycles → 16 pairs out on consecutive cycles, in_ready stays 1.

REQ-028 Reset in FULL: assert rst=0 → out_valid=0 and in_ready=1 immediately, nothing emitted after release.
